// File: rtl/mem_bus_adapter.sv
// Memory bus adapter: turns the multicycle core's fetch/load/store strobes into a
// req/ack bus transaction, stalling the control FSM until the access completes.
module mem_bus_adapter #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                TIMEOUT  = 255,
    parameter logic [DATA_W-1:0] ERR_DATA = 32'h00100073
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              ir_write,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              stall,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              bus_err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

    logic [1:0]  state;
    logic [15:0] timer;
    logic        access;
    logic        conflict;
    logic        misaligned;

    assign access     = ir_write | mem_read | mem_write;
    assign conflict   = (ir_write & mem_read) | (ir_write & mem_write) | (mem_read & mem_write);
    assign misaligned = (addr[1:0] != 2'b00);

    // Stall starts combinationally so the control FSM holds on the very edge the strobe appears.
    assign stall = ((state == IDLE) && access) || (state == REQ);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            timer       <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            bus_err     <= 1'b0;
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= '0;
            bus_wdata   <= '0;
        end else begin
            rdata_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (access) begin
                        if (conflict) begin
                            bus_err <= 1'b1;
                        end
                        // Misaligned accesses never reach the bus; reads get the EBREAK word.
                        if (misaligned) begin
                            bus_err <= 1'b1;
                            if (!mem_write) begin
                                rdata       <= ERR_DATA;
                                rdata_valid <= 1'b1;
                            end
                            state <= DONE;
                        end else begin
                            bus_req   <= 1'b1;
                            bus_we    <= mem_write;
                            bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
                            bus_wdata <= wdata;
                            timer     <= '0;
                            state     <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        state   <= DONE;
                        if (!bus_we) begin
                            rdata       <= bus_rdata;
                            rdata_valid <= 1'b1;
                        end
                    end else if (timer == TIMER_LAST) begin
                        bus_req <= 1'b0;
                        bus_err <= 1'b1;
                        state   <= DONE;
                        if (!bus_we) begin
                            rdata       <= ERR_DATA;
                            rdata_valid <= 1'b1;
                        end
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_adapter.sv
// Self-checking bench for mem_bus_adapter: a transaction-level model predicts every
// cycle of each access, plus literal checks of stall/request lengths and final data.
module tb_mem_bus_adapter;

    localparam int          TO       = 4;
    localparam logic [31:0] ERR_WORD = 32'h00100073;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        ir_write = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        bus_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;

    always #5 clk = ~clk;

    mem_bus_adapter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (TO),
        .ERR_DATA(ERR_WORD)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .ir_write   (ir_write),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .addr       (addr),
        .wdata      (wdata),
        .stall      (stall),
        .rdata      (rdata),
        .rdata_valid(rdata_valid),
        .bus_err    (bus_err),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_ack    (bus_ack),
        .bus_rdata  (bus_rdata)
    );

    int tests_run = 0;
    int tests_failed = 0;

    // Architectural state carried between transactions by the model.
    logic [31:0] m_rdata = '0;
    logic        m_err = 1'b0;

    logic        exp_valid = 1'b0;
    logic        e_stall, e_req, e_we, e_valid, e_err;
    logic [31:0] e_addr, e_wdata, e_rdata;

    logic count_en = 1'b0;
    int   stall_seen, req_seen, valid_seen;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_valid) begin
            checkOutput("stall", 32'(stall), 32'(e_stall));
            checkOutput("bus_req", 32'(bus_req), 32'(e_req));
            checkOutput("rdata", rdata, e_rdata);
            checkOutput("rdata_valid", 32'(rdata_valid), 32'(e_valid));
            checkOutput("bus_err", 32'(bus_err), 32'(e_err));
            if (e_req) begin
                checkOutput("bus_we", 32'(bus_we), 32'(e_we));
                checkOutput("bus_addr", bus_addr, e_addr);
                checkOutput("bus_wdata", bus_wdata, e_wdata);
            end
            if (count_en) begin
                if (stall) stall_seen++;
                if (bus_req) req_seen++;
                if (rdata_valid) valid_seen++;
            end
        end
    end

    task automatic setIdleExpect();
        e_stall   = 1'b0;
        e_req     = 1'b0;
        e_rdata   = m_rdata;
        e_valid   = 1'b0;
        e_err     = m_err;
        exp_valid = 1'b1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_stall"}, 32'(stall), 32'd0);
        checkOutput({tag, "_bus_req"}, 32'(bus_req), 32'd0);
        checkOutput({tag, "_bus_we"}, 32'(bus_we), 32'd0);
        checkOutput({tag, "_bus_addr"}, bus_addr, 32'd0);
        checkOutput({tag, "_bus_wdata"}, bus_wdata, 32'd0);
        checkOutput({tag, "_rdata"}, rdata, 32'd0);
        checkOutput({tag, "_rdata_valid"}, 32'(rdata_valid), 32'd0);
        checkOutput({tag, "_bus_err"}, 32'(bus_err), 32'd0);
    endtask

    task automatic resetAndCheck(input string tag);
        exp_valid = 1'b0;
        ir_write  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        bus_ack   = 1'b0;
        resetn    = 1'b0;
        #1;
        checkAllZero(tag);
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        m_rdata = '0;
        m_err   = 1'b0;
        setIdleExpect();
    endtask

    // One complete access as the control FSM would drive it: strobes held until the
    // DONE cycle, the bench acting as memory with k wait states (k >= TO never acks).
    task automatic applyStimulus(input logic fetch, input logic rd, input logic wr,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 input int k, input logic [31:0] rd_val);
        logic        conflict, is_read, mis, timed_out, new_err;
        logic [31:0] new_rdata;
        int          n;
        conflict  = (int'(fetch) + int'(rd) + int'(wr)) > 1;
        is_read   = !wr;
        mis       = (a[1:0] != 2'b00);
        timed_out = !mis && (k >= TO);
        n         = mis ? 0 : (timed_out ? TO : k + 1);
        new_err   = m_err | conflict | mis | timed_out;
        new_rdata = !is_read ? m_rdata : ((mis || timed_out) ? ERR_WORD : rd_val);
        stall_seen = 0;
        req_seen   = 0;
        valid_seen = 0;
        count_en   = 1'b1;
        for (int c = 0; c <= n + 1; c++) begin
            @(posedge clk);
            #1;
            ir_write  = fetch;
            mem_read  = rd;
            mem_write = wr;
            addr      = a;
            wdata     = wd;
            bus_ack   = (c >= 1) && (c <= n) && !timed_out && (c - 1 == k);
            bus_rdata = bus_ack ? rd_val : (32'hBAD00000 | 32'(c));
            e_we      = wr;
            e_addr    = {a[31:2], 2'b00};
            e_wdata   = wd;
            if (c == 0) begin
                e_stall = 1'b1; e_req = 1'b0; e_rdata = m_rdata; e_valid = 1'b0; e_err = m_err;
            end else if (c <= n) begin
                e_stall = 1'b1; e_req = 1'b1; e_rdata = m_rdata; e_valid = 1'b0; e_err = m_err | conflict;
            end else begin
                e_stall = 1'b0; e_req = 1'b0; e_rdata = new_rdata; e_valid = is_read; e_err = new_err;
            end
            exp_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        ir_write  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        bus_ack   = 1'b0;
        count_en  = 1'b0;
        m_rdata   = new_rdata;
        m_err     = new_err;
        setIdleExpect();
    endtask

    task automatic idleCycles(input int n, input logic ack);
        repeat (n) begin
            @(posedge clk);
            #1;
            bus_ack   = ack;
            bus_rdata = 32'hFFFF0000;
            setIdleExpect();
        end
    endtask

    initial begin
        #1;
        resetAndCheck("reset");

        applyStimulus(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 0, 32'h00500093);
        checkOutput("t1_stall_cycles", 32'(stall_seen), 32'd2);
        checkOutput("t1_req_cycles", 32'(req_seen), 32'd1);
        checkOutput("t1_valid_pulses", 32'(valid_seen), 32'd1);
        checkOutput("t1_rdata", rdata, 32'h00500093);
        idleCycles(2, 1'b0);

        applyStimulus(1'b0, 1'b0, 1'b1, 32'h200, 32'hDEADBEEF, 3, 32'h11111111);
        checkOutput("t2_stall_cycles", 32'(stall_seen), 32'd5);
        checkOutput("t2_req_cycles", 32'(req_seen), 32'd4);
        checkOutput("t2_valid_pulses", 32'(valid_seen), 32'd0);
        checkOutput("t2_rdata_kept", rdata, 32'h00500093);

        applyStimulus(1'b0, 1'b1, 1'b0, 32'h104, 32'h0, 1, 32'h12345678);
        checkOutput("load_rdata", rdata, 32'h12345678);
        checkOutput("load_err", 32'(bus_err), 32'd0);

        applyStimulus(1'b0, 1'b1, 1'b0, 32'h300, 32'h0, 1000, 32'h55555555);
        checkOutput("t3_req_cycles", 32'(req_seen), 32'd4);
        checkOutput("t3_stall_cycles", 32'(stall_seen), 32'd5);
        checkOutput("t3_err", 32'(bus_err), 32'd1);
        checkOutput("t3_rdata", rdata, 32'h00100073);

        resetAndCheck("reset_t4");
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h102, 32'h0, 0, 32'h0);
        checkOutput("t4_stall_cycles", 32'(stall_seen), 32'd1);
        checkOutput("t4_req_cycles", 32'(req_seen), 32'd0);
        checkOutput("t4_err", 32'(bus_err), 32'd1);
        checkOutput("t4_rdata", rdata, 32'h00100073);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h203, 32'hA5A5A5A5, 0, 32'h0);
        checkOutput("mis_write_rdata", rdata, 32'h00100073);
        checkOutput("mis_write_valid", 32'(valid_seen), 32'd0);

        resetAndCheck("reset_t5");
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h40, 32'h0BADF00D, 2, 32'h77777777);
        checkOutput("t5_err", 32'(bus_err), 32'd1);
        checkOutput("t5_rdata", rdata, 32'h0);
        checkOutput("t5_req_cycles", 32'(req_seen), 32'd3);
        idleCycles(3, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h44, 32'h0, 0, 32'hCAFEF00D);
        checkOutput("t5_after_stray_rdata", rdata, 32'hCAFEF00D);

        exp_valid = 1'b0;
        @(posedge clk);
        #1;
        ir_write = 1'b1;
        addr     = 32'h80;
        bus_ack  = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("t6_req_before_reset", 32'(bus_req), 32'd1);
        #2;
        resetAndCheck("t6_reset");
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h84, 32'h0, 1, 32'h00A00113);
        checkOutput("t6_refetch_rdata", rdata, 32'h00A00113);
        checkOutput("t6_refetch_err", 32'(bus_err), 32'd0);

        idleCycles(2, 1'b0);
        exp_valid = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
